// File: rtl/decoder_sequencer_if.sv
// Requester / decoder side signals of the decoder sequencer.
// slave: the sequencer itself; master: requesters + decoder (or a bench).
interface decoder_sequencer_if #(
    parameter int CODE_W = 7
);
    logic              a_valid;
    logic [CODE_W-1:0] a_code;
    logic              a_ready;
    logic              b_valid;
    logic [CODE_W-1:0] b_code;
    logic              b_ready;
    logic [CODE_W-1:0] dec_code;
    logic              dec_ctrl;
    logic              dec_reset;
    logic [3:0]        dec_state;
    logic              owner;
    logic              busy;
    logic              seq_done;
    logic              seq_err;
    logic              lockout;
    logic [1:0]        err_cnt;

    modport slave (
        input  a_valid, a_code, b_valid, b_code, dec_state,
        output a_ready, b_ready, dec_code, dec_ctrl, dec_reset,
               owner, busy, seq_done, seq_err, lockout, err_cnt
    );

    modport master (
        output a_valid, a_code, b_valid, b_code, dec_state,
        input  a_ready, b_ready, dec_code, dec_ctrl, dec_reset,
               owner, busy, seq_done, seq_err, lockout, err_cnt
    );
endinterface

// File: rtl/decoder_sequencer.sv
// Shares one code-word position decoder between requesters A and B.
// Round-robin grant per session, one code per handshake, decoder state
// sampled SETTLE cycles after the strobe, clear on terminal/error results,
// consecutive-error lockout and idle-session timeout.
module decoder_sequencer #(
    parameter int CODE_W   = 7,
    parameter int SETTLE   = 1,
    parameter int MAX_ERR  = 3,
    parameter int LOCK_CYC = 16,
    parameter int SESS_TO  = 64
) (
    input  logic                 clk,
    input  logic                 Reset,
    decoder_sequencer_if.slave   sq
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_LOCK  = 3'd5;

    // one counter serves both the settle wait and the lockout window
    localparam int CMAX = (SETTLE > LOCK_CYC) ? SETTLE : LOCK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(SESS_TO + 1);

    logic [2:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              sess_q, sess_d;
    logic [CODE_W-1:0] lat_q, lat_d;
    logic [CODE_W-1:0] dcode_q, dcode_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;

    logic a_rdy, b_rdy, drst, done, fail, expire;
    logic [1:0] err_inc;

    // next-state, handshake and pulse decode
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        sess_d  = sess_q;
        lat_d   = lat_q;
        dcode_d = dcode_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        drst    = 1'b0;
        done    = 1'b0;
        fail    = 1'b0;
        err_inc = (err_q == 2'd3) ? 2'd3 : err_q + 2'd1;
        expire  = sess_q && (timer_q == TW'(SESS_TO - 1));
        case (state_q)
            S_IDLE: begin
                if (expire) begin
                    // timeout beats a same-cycle handshake
                    fail    = 1'b1;
                    err_d   = err_inc;
                    state_d = S_CLEAR;
                end else begin
                    if (sess_q) begin
                        a_rdy = !owner_q && sq.a_valid;
                        b_rdy = owner_q && sq.b_valid;
                    end else if (sq.a_valid && sq.b_valid) begin
                        a_rdy = last_q;
                        b_rdy = !last_q;
                    end else begin
                        a_rdy = sq.a_valid;
                        b_rdy = sq.b_valid;
                    end
                    if (a_rdy || b_rdy) begin
                        lat_d   = b_rdy ? sq.b_code : sq.a_code;
                        owner_d = b_rdy;
                        state_d = S_ISSUE;
                    end else if (sess_q) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_ISSUE: begin
                dcode_d = lat_q;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CW'(SETTLE - 1)) state_d = S_CHECK;
                else                          cnt_d   = cnt_q + CW'(1);
            end
            S_CHECK: begin
                case (sq.dec_state)
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                        sess_d  = 1'b1;
                        timer_d = '0;
                        state_d = S_IDLE;
                    end
                    4'd0: begin
                        sess_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                    4'd9, 4'd10: begin
                        done    = 1'b1;
                        err_d   = 2'd0;
                        state_d = S_CLEAR;
                    end
                    default: begin
                        fail   = 1'b1;
                        err_d  = err_inc;
                        sess_d = 1'b0;
                        if (32'(err_inc) >= MAX_ERR) begin
                            cnt_d   = '0;
                            state_d = S_LOCK;
                        end else begin
                            state_d = S_CLEAR;
                        end
                    end
                endcase
            end
            S_CLEAR: begin
                drst    = 1'b1;
                sess_d  = 1'b0;
                timer_d = '0;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            S_LOCK: begin
                drst = (cnt_q == '0);
                if (cnt_q == CW'(LOCK_CYC - 1)) begin
                    err_d   = 2'd0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers, synchronous reset (last owner = B so A wins first tie)
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sess_q  <= 1'b0;
            lat_q   <= '0;
            dcode_q <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sess_q  <= sess_d;
            lat_q   <= lat_d;
            dcode_q <= dcode_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // outputs are forced quiet while Reset is high, except dec_reset
    always_comb begin
        sq.a_ready   = !Reset && a_rdy;
        sq.b_ready   = !Reset && b_rdy;
        sq.dec_ctrl  = !Reset && (state_q == S_ISSUE);
        sq.dec_code  = Reset ? '0 : ((state_q == S_ISSUE) ? lat_q : dcode_q);
        sq.dec_reset = Reset || drst;
        sq.owner     = !Reset && owner_q;
        sq.busy      = !Reset && ((state_q != S_IDLE) || sess_q);
        sq.seq_done  = !Reset && done;
        sq.seq_err   = !Reset && fail;
        sq.lockout   = !Reset && (state_q == S_LOCK);
        sq.err_cnt   = Reset ? 2'd0 : err_q;
    end
endmodule

// File: tb/tb_decoder_sequencer.sv
// Random-stimulus bench for decoder_sequencer against a timeline model:
// each accepted code is tracked by its age since accept, lockout and
// session idleness by plain countdown/count integers.
module tb_decoder_sequencer;
    localparam int CODE_W   = 7;
    localparam int SETTLE   = 1;
    localparam int MAX_ERR  = 3;
    localparam int LOCK_CYC = 16;
    localparam int SESS_TO  = 64;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    decoder_sequencer_if #(.CODE_W(CODE_W)) sq ();

    decoder_sequencer #(
        .CODE_W(CODE_W), .SETTLE(SETTLE), .MAX_ERR(MAX_ERR),
        .LOCK_CYC(LOCK_CYC), .SESS_TO(SESS_TO)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .sq(sq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    int          age;        // cycles since accept, 0 = nothing in flight
    int          lock_left;
    bit          clr;
    bit          sess;
    int          idle;
    bit          own, last;
    int          errs;
    logic [CODE_W-1:0] lat, lastc;
    int          n_lock, n_tmo, n_done, n_grant_b_tie;

    task automatic model_reset();
        age = 0; lock_left = 0; clr = 0; sess = 0; idle = 0;
        own = 0; last = 1; errs = 0; lat = '0; lastc = '0;
    endtask

    // one clock: drive at negedge, compare after settling, advance model
    task automatic cycle(input bit rst, input int pv, input int mode);
        bit e_ar, e_br, e_ctrl, e_rst, e_busy, e_done, e_err, e_lock;
        logic [CODE_W-1:0] e_code;
        int  e_errs;
        bit  e_own, av, bv, ga, gb;
        int  d;
        @(negedge clk);
        Reset = rst;
        av = ($urandom_range(99) < pv);
        bv = ($urandom_range(99) < pv);
        sq.a_valid = av;
        sq.b_valid = bv;
        sq.a_code  = CODE_W'($urandom);
        sq.b_code  = CODE_W'($urandom);
        case (mode)
            1: d = 8;
            2: d = 3;
            default: begin
                case ($urandom_range(10))
                    0: d = 0;  1: d = 1;  2: d = 2;  3: d = 4;  4: d = 5;
                    5: d = 8;  6: d = 9;  7: d = 10; 8: d = 11; 9: d = 15;
                    default: d = 3;
                endcase
            end
        endcase
        sq.dec_state = 4'(d);
        #1;
        e_ar = 0; e_br = 0; e_ctrl = 0; e_rst = 0; e_busy = 0;
        e_done = 0; e_err = 0; e_lock = 0;
        e_code = lastc; e_errs = errs; e_own = own;
        if (rst) begin
            e_rst = 1; e_code = '0; e_errs = 0;
            model_reset();
        end else if (lock_left > 0) begin
            e_lock = 1; e_busy = 1;
            e_rst = (lock_left == LOCK_CYC);
            lock_left--;
            if (lock_left == 0) begin errs = 0; last = own; end
        end else if (clr) begin
            e_rst = 1; e_busy = 1;
            clr = 0; sess = 0; last = own;
        end else if (age > 0) begin
            e_busy = 1;
            if (age == 1) begin e_ctrl = 1; e_code = lat; lastc = lat; end
            if (age == SETTLE + 2) begin
                age = 0;
                if (d >= 1 && d <= 5) begin
                    sess = 1; idle = 0;
                end else if (d == 0) begin
                    sess = 0;
                end else if (d == 9 || d == 10) begin
                    e_done = 1; errs = 0; clr = 1; n_done++;
                end else begin
                    e_err = 1; sess = 0;
                    errs = (errs < 3) ? errs + 1 : 3;
                    if (errs >= MAX_ERR) begin lock_left = LOCK_CYC; n_lock++; end
                    else clr = 1;
                end
            end else begin
                age++;
            end
        end else begin
            e_busy = sess;
            if (sess && idle == SESS_TO - 1) begin
                e_err = 1; clr = 1; n_tmo++;
                errs = (errs < 3) ? errs + 1 : 3;
            end else begin
                ga = 0; gb = 0;
                if (sess) begin
                    ga = !own && av; gb = own && bv;
                end else if (av && bv) begin
                    if (last) ga = 1; else begin gb = 1; n_grant_b_tie++; end
                end else begin
                    ga = av; gb = bv;
                end
                if (ga || gb) begin
                    e_ar = ga; e_br = gb;
                    lat = gb ? sq.b_code : sq.a_code;
                    own = gb; age = 1;
                end else if (sess) begin
                    idle++;
                end
            end
        end
        chk("a_ready",   sq.a_ready,   e_ar);
        chk("b_ready",   sq.b_ready,   e_br);
        chk("dec_ctrl",  sq.dec_ctrl,  e_ctrl);
        chk("dec_code",  sq.dec_code,  e_code);
        chk("dec_reset", sq.dec_reset, e_rst);
        chk("busy",      sq.busy,      e_busy);
        chk("seq_done",  sq.seq_done,  e_done);
        chk("seq_err",   sq.seq_err,   e_err);
        chk("lockout",   sq.lockout,   e_lock);
        chk("err_cnt",   sq.err_cnt,   e_errs);
        if (e_busy) chk("owner", sq.owner, e_own);
        if (rst)    chk("owner_rst", sq.owner, 0);
    endtask

    task automatic run(input int n, input bit rst, input int pv, input int mode);
        for (int i = 0; i < n; i++) cycle(rst, pv, mode);
    endtask

    initial begin
        sq.a_valid = 0; sq.b_valid = 0; sq.a_code = '0; sq.b_code = '0;
        sq.dec_state = '0;
        n_lock = 0; n_tmo = 0; n_done = 0; n_grant_b_tie = 0;
        model_reset();
        run(3, 1, 50, 0);
        // first grants after reset, including a tie that must go to A
        run(2, 0, 100, 0);
        run(500, 0, 50, 0);
        run(2, 1, 80, 0);     // reset mid-activity
        run(60, 0, 90, 1);    // back-to-back errors -> lockout
        run(20, 0, 80, 2);    // open sessions
        run(80, 0, 0, 2);     // go silent -> session timeout
        run(20, 0, 80, 2);
        run(80, 0, 0, 2);
        run(600, 0, 60, 0);
        run(3, 1, 60, 0);
        run(300, 0, 70, 0);
        chk("cov_lockout", n_lock > 0, 1);
        chk("cov_timeout", n_tmo > 0, 1);
        chk("cov_done",    n_done > 0, 1);
        chk("cov_tie_b",   n_grant_b_tie > 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
